// File: rtl/fetch_unit.sv
// PC generation and instruction prefetch queue sitting in front of the instruction cache.
// Define FETCH_PERF_EN to add saturating stall/fetch performance counters.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                FQ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          ic_pc,
  input  logic [DATA_W-1:0]          ic_instr,
  input  logic                       ic_stall,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       dec_valid,
  output logic [DATA_W-1:0]          dec_instr,
  output logic [ADDR_W-1:0]          dec_pc,
  input  logic                       dec_ready,
  output logic [$clog2(FQ_DEPTH):0]  fq_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_fetch_cnt
`endif
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {RUN, MISS, MISS_REDIR} state_t;

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [ADDR_W-1:0] pend, pend_nx;
  logic              push, pop, flush;

  logic [ADDR_W-1:0] fq_pc    [FQ_DEPTH];
  logic [DATA_W-1:0] fq_instr [FQ_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;

  assign ic_pc     = pc;
  assign fq_count  = count;
  assign dec_valid = (count != '0);
  assign dec_instr = dec_valid ? fq_instr[rptr] : '0;
  assign dec_pc    = dec_valid ? fq_pc[rptr]    : '0;

  // Any redirect kills the queue contents, so it also cancels a pop that cycle.
  assign flush = redirect_valid;
  assign pop   = dec_valid & dec_ready & ~flush;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    pend_nx  = pend;
    push     = 1'b0;
    case (state)
      RUN, MISS: begin
        if (redirect_valid) begin
          if (ic_stall) begin
            pend_nx  = align(redirect_pc);
            state_nx = MISS_REDIR;
          end else begin
            pc_nx    = align(redirect_pc);
            state_nx = RUN;
          end
        end else if (ic_stall) begin
          state_nx = MISS;
        end else begin
          state_nx = RUN;
          if ((count < CW'(FQ_DEPTH)) || pop) begin
            push  = 1'b1;
            pc_nx = pc + ADDR_W'(4);
          end
        end
      end
      MISS_REDIR: begin
        // The instruction returned at the end of this miss is stale and is dropped.
        if (redirect_valid) begin
          if (ic_stall) begin
            pend_nx = align(redirect_pc);
          end else begin
            pc_nx    = align(redirect_pc);
            state_nx = RUN;
          end
        end else if (!ic_stall) begin
          pc_nx    = pend;
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= align(RESET_PC);
      pend  <= '0;
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      pend  <= pend_nx;
      if (flush) begin
        count <= '0;
        wptr  <= '0;
        rptr  <= '0;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
      end
    end
  end

  // Queue storage carries data only; occupancy tracking above makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_pc[wptr]    <= pc;
      fq_instr[wptr] <= ic_instr;
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_fetch_cnt <= '0;
    end else begin
      if (ic_stall) perf_stall_cnt <= sat_inc(perf_stall_cnt);
      if (push)     perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random traffic
// compared against a queue-based reference model.
module tb_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] ic_pc;
  logic [31:0] ic_instr;
  logic        ic_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic [2:0]  fq_count;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_fetch_cnt;
`endif

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .ic_pc(ic_pc),
    .ic_instr(ic_instr),
    .ic_stall(ic_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .dec_valid(dec_valid),
    .dec_instr(dec_instr),
    .dec_pc(dec_pc),
    .dec_ready(dec_ready),
    .fq_count(fq_count)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_fetch_cnt(perf_fetch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Reference model: program counter, a pending redirect target, and a plain queue.
  entry_t      m_q[$];
  logic [31:0] m_pc;
  logic        m_pend_vld;
  logic [31:0] m_pend;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_fetch_cnt;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] v, input bit inc);
    if (!inc || v == 32'hFFFF_FFFF) return v;
    return v + 32'd1;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit rv, input logic [31:0] rp,
                            input bit rd, input logic [31:0] instr);
    bit do_pop, do_push;
    entry_t e;
    if (r) begin
      m_q.delete();
      m_pc = RST_PC;
      m_pend_vld = 1'b0;
      m_pend = '0;
      m_stall_cnt = '0;
      m_fetch_cnt = '0;
      return;
    end
    do_pop  = (m_q.size() != 0) && rd;
    do_push = 1'b0;
    if (rv) begin
      if (s) begin
        m_pend_vld = 1'b1;
        m_pend = {rp[31:2], 2'b00};
      end else begin
        m_pend_vld = 1'b0;
        m_pc = {rp[31:2], 2'b00};
      end
    end else if (!s) begin
      if (m_pend_vld) begin
        m_pc = m_pend;
        m_pend_vld = 1'b0;
      end else if (m_q.size() < DEPTH || do_pop) begin
        do_push = 1'b1;
      end
    end
    if (rv) begin
      m_q.delete();
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        e.pc = m_pc;
        e.instr = instr;
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    m_stall_cnt = sat_add(m_stall_cnt, s);
    m_fetch_cnt = sat_add(m_fetch_cnt, do_push);
  endtask

  task automatic compare_all();
    check("ic_pc", 64'(ic_pc), 64'(m_pc));
    check("fq_count", 64'(fq_count), 64'(m_q.size()));
    check("dec_valid", 64'(dec_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("dec_pc", 64'(dec_pc), 64'(m_q[0].pc));
      check("dec_instr", 64'(dec_instr), 64'(m_q[0].instr));
    end else begin
      check("dec_pc_empty", 64'(dec_pc), 64'd0);
      check("dec_instr_empty", 64'(dec_instr), 64'd0);
    end
`ifdef FETCH_PERF_EN
    check("perf_stall", 64'(perf_stall_cnt), 64'(m_stall_cnt));
    check("perf_fetch", 64'(perf_fetch_cnt), 64'(m_fetch_cnt));
`endif
  endtask

  // One clock: drive inputs, advance the model, then sample at the falling edge.
  task automatic cyc(input bit r, input bit s, input bit rv, input logic [31:0] rp, input bit rd);
    rst = r;
    ic_stall = s;
    redirect_valid = rv;
    redirect_pc = rp;
    dec_ready = rd;
    ic_instr = m_pc ^ 32'hA5A5_0000;
    model_step(r, s, rv, rp, rd, ic_instr);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    m_pc = RST_PC;
    // Straight-line fetch with decode always ready.
    cyc(1, 0, 0, 0, 1);
    check("reset_count", 64'(fq_count), 64'd0);
    check("reset_pc", 64'(ic_pc), 64'(RST_PC));
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1);
      check("seq_dec_pc", 64'(dec_pc), 64'(i * 4));
      check("seq_dec_instr", 64'(dec_instr), 64'((i * 4) ^ 32'hA5A5_0000));
    end

    // Fill with decode blocked, then one push+pop at full.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    check("full_count", 64'(fq_count), 64'd4);
    check("full_pc", 64'(ic_pc), 64'h10);
    cyc(0, 0, 0, 0, 0);
    check("full_hold_pc", 64'(ic_pc), 64'h10);
    cyc(0, 0, 0, 0, 1);
    check("pushpop_count", 64'(fq_count), 64'd4);
    check("pushpop_pc", 64'(ic_pc), 64'h14);

    // Ten-cycle miss at 0x1C.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("pre_miss_pc", 64'(ic_pc), 64'h1C);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0, 0);
      check("miss_hold_pc", 64'(ic_pc), 64'h1C);
    end
    cyc(0, 0, 0, 0, 1);
    check("miss_done_pc", 64'(ic_pc), 64'h20);

    // Redirect with three queued entries.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    check("three_queued", 64'(fq_count), 64'd3);
    cyc(0, 0, 1, 32'h57, 1);
    check("redir_count", 64'(fq_count), 64'd0);
    check("redir_valid", 64'(dec_valid), 64'd0);
    check("redir_pc", 64'(ic_pc), 64'h54);

    // Redirect arriving during a miss at 0x54.
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 32'h24, 1);
    check("miss_redir_hold", 64'(ic_pc), 64'h54);
    cyc(0, 1, 0, 0, 1);
    check("miss_redir_hold2", 64'(ic_pc), 64'h54);
    cyc(0, 0, 0, 0, 1);
    check("miss_redir_pc", 64'(ic_pc), 64'h24);
    check("miss_redir_drop", 64'(fq_count), 64'd0);
    cyc(0, 0, 0, 0, 0);
    check("miss_redir_first", 64'(dec_pc), 64'h24);

    // PC wraps modulo 2^32.
    cyc(0, 0, 1, 32'hFFFF_FFFE, 0);
    check("wrap_align", 64'(ic_pc), 64'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);
    check("wrap_pc", 64'(ic_pc), 64'h0);

    // Reset mid-miss with a full queue, redirect also raised.
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 1, 32'h88, 1);
    check("rst_miss_pc", 64'(ic_pc), 64'(RST_PC));
    check("rst_miss_count", 64'(fq_count), 64'd0);
    check("rst_miss_valid", 64'(dec_valid), 64'd0);
`ifdef FETCH_PERF_EN
    check("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
    check("rst_perf_fetch", 64'(perf_fetch_cnt), 64'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) < 2),
          ($urandom_range(99) < 30),
          ($urandom_range(99) < 8),
          $urandom,
          ($urandom_range(99) < 60));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
